// File: rtl/rom_port_arbiter.sv
// Arbitrates the single ROM port between the switch loader, CPU fetch and scan reader.
// One transaction in flight at a time; the scan reader is protected from CPU starvation.
module rom_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [1:0]        i_mode,
  input  logic              i_ld_req,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_ld_ack,
  input  logic              i_cpu_req,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_data,
  input  logic              i_scan_req,
  input  logic [ADDR_W-1:0] i_scan_addr,
  output logic              o_scan_ack,
  output logic [DATA_W-1:0] o_scan_data,
  output logic              o_rom_en,
  output logic              o_rom_we,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic [DATA_W-1:0] o_rom_wdata,
  input  logic [DATA_W-1:0] i_rom_rdata,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_LD, SRC_CPU, SRC_SCAN} src_t;

  state_t            r_state;
  state_t            w_next;
  src_t              r_winner;
  src_t              w_pick;
  logic [2:0]        r_starve;
  logic [2:0]        r_waitCnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpuData;
  logic [DATA_W-1:0] r_scanData;

  logic w_eligLd;
  logic w_eligCpu;
  logic w_eligScan;
  logic w_starved;
  logic w_lastWait;

  // Mode 0 is switch entry (loader only); modes 1..3 are run/debug (readers only).
  assign w_eligLd   = (i_mode == 2'd0) && i_ld_req;
  assign w_eligCpu  = (i_mode != 2'd0) && i_cpu_req;
  assign w_eligScan = (i_mode != 2'd0) && i_scan_req;
  assign w_starved  = (r_starve == 3'(STARVE_MAX)) && i_scan_req;
  assign w_lastWait = (r_waitCnt == 3'(RD_LAT - 1));

  always_comb begin
    w_pick = SRC_NONE;
    if (w_eligLd)
      w_pick = SRC_LD;
    else if (w_eligScan && w_starved)
      w_pick = SRC_SCAN;
    else if (w_eligCpu)
      w_pick = SRC_CPU;
    else if (w_eligScan)
      w_pick = SRC_SCAN;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_pick != SRC_NONE) w_next = GRANT;
      GRANT:   w_next = (r_winner == SRC_LD) ? DONE : WAIT;
      WAIT:    if (w_lastWait) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_winner   <= SRC_NONE;
      r_starve   <= 3'd0;
      r_waitCnt  <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpuData  <= '0;
      r_scanData <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_waitCnt <= 3'd0;
          if (w_pick != SRC_NONE)
            r_winner <= w_pick;
          case (w_pick)
            SRC_LD: begin
              r_addr  <= i_ld_addr;
              r_wdata <= i_ld_data;
            end
            SRC_CPU:  r_addr <= i_cpu_addr;
            SRC_SCAN: r_addr <= i_scan_addr;
            default: ;
          endcase
          // The counter only measures CPU wins that actually overtook a waiting scan.
          if (!i_scan_req || (w_pick == SRC_SCAN))
            r_starve <= 3'd0;
          else if ((w_pick == SRC_CPU) && (r_starve < 3'(STARVE_MAX)))
            r_starve <= r_starve + 3'd1;
        end
        WAIT: begin
          r_waitCnt <= r_waitCnt + 3'd1;
          if (w_lastWait) begin
            if (r_winner == SRC_CPU)
              r_cpuData <= i_rom_rdata;
            else if (r_winner == SRC_SCAN)
              r_scanData <= i_rom_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_rom_en   = (r_state == GRANT);
    o_rom_we   = (r_state == GRANT) && (r_winner == SRC_LD);
    o_ld_ack   = (r_state == DONE) && (r_winner == SRC_LD);
    o_cpu_ack  = (r_state == DONE) && (r_winner == SRC_CPU);
    o_scan_ack = (r_state == DONE) && (r_winner == SRC_SCAN);
    o_busy     = (r_state != IDLE);
  end

  assign o_rom_addr  = r_addr;
  assign o_rom_wdata = r_wdata;
  assign o_cpu_data  = r_cpuData;
  assign o_scan_data = r_scanData;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: default build plus an RD_LAT=3 build,
// with a ROM model and a scoreboard of expected acks.
module tb_rom_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN;
  logic [1:0]    mode;
  logic          ldReq, cpuReq, scanReq;
  logic [AW-1:0] ldAddr, cpuAddr, scanAddr;
  logic [DW-1:0] ldData;
  logic          ldAck, cpuAck, scanAck, romEn, romWe, busy;
  logic [DW-1:0] cpuData, scanData, romWdata, romRdata;
  logic [AW-1:0] romAddr;

  logic [1:0]    bMode;
  logic          bLdReq, bCpuReq, bScanReq;
  logic [AW-1:0] bLdAddr, bCpuAddr, bScanAddr;
  logic [DW-1:0] bLdData;
  logic          bLdAck, bCpuAck, bScanAck, bRomEn, bRomWe, bBusy;
  logic [DW-1:0] bCpuData, bScanData, bRomWdata, bRomRdata;
  logic [AW-1:0] bRomAddr;

  rom_port_arbiter dut (
    .i_clk(clk), .i_reset_n(rstN), .i_mode(mode),
    .i_ld_req(ldReq), .i_ld_addr(ldAddr), .i_ld_data(ldData), .o_ld_ack(ldAck),
    .i_cpu_req(cpuReq), .i_cpu_addr(cpuAddr), .o_cpu_ack(cpuAck), .o_cpu_data(cpuData),
    .i_scan_req(scanReq), .i_scan_addr(scanAddr), .o_scan_ack(scanAck), .o_scan_data(scanData),
    .o_rom_en(romEn), .o_rom_we(romWe), .o_rom_addr(romAddr), .o_rom_wdata(romWdata),
    .i_rom_rdata(romRdata), .o_busy(busy)
  );

  rom_port_arbiter #(.RD_LAT(3)) dutLat3 (
    .i_clk(clk), .i_reset_n(rstN), .i_mode(bMode),
    .i_ld_req(bLdReq), .i_ld_addr(bLdAddr), .i_ld_data(bLdData), .o_ld_ack(bLdAck),
    .i_cpu_req(bCpuReq), .i_cpu_addr(bCpuAddr), .o_cpu_ack(bCpuAck), .o_cpu_data(bCpuData),
    .i_scan_req(bScanReq), .i_scan_addr(bScanAddr), .o_scan_ack(bScanAck), .o_scan_data(bScanData),
    .o_rom_en(bRomEn), .o_rom_we(bRomWe), .o_rom_addr(bRomAddr), .o_rom_wdata(bRomWdata),
    .i_rom_rdata(bRomRdata), .o_busy(bBusy)
  );

  function automatic logic [DW-1:0] romInit(input logic [AW-1:0] a);
    case (a)
      11'h020: romInit = 16'h1234;
      11'h001: romInit = 16'hBEEF;
      11'h030: romInit = 16'hC030;
      11'h040: romInit = 16'hD040;
      11'h050: romInit = 16'h5050;
      11'h7FE: romInit = 16'h7E7E;
      default: romInit = {5'b0, a} ^ 16'h6C00;
    endcase
  endfunction

  // ROM models: writable one-cycle ROM for the default build, read-only 3-stage for the other.
  logic [DW-1:0] mem [0:2047];
  bit            wr  [0:2047];
  logic [DW-1:0] b1, b2;

  always @(posedge clk) begin
    if (romEn && romWe) begin
      mem[romAddr] <= romWdata;
      wr[romAddr]  <= 1'b1;
    end
    if (romEn && !romWe)
      romRdata <= wr[romAddr] ? mem[romAddr] : romInit(romAddr);
  end

  always @(posedge clk) begin
    if (bRomEn) b1 <= romInit(bRomAddr);
    b2        <= b1;
    bRomRdata <= b2;
  end

  typedef struct {
    string         tag;
    logic [2:0]    ackVec;
    logic [DW-1:0] data;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   reqCyc = 0;
  logic ackSeen;
  logic busySeen;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [2:0] vec, input logic [DW-1:0] d, input int lat);
    exp_t e;
    e.tag = tag; e.ackVec = vec; e.data = d; e.lat = lat;
    sb.push_back(e);
  endtask

  // Waits for any ack on the selected instance, then checks it against the oldest expectation.
  task automatic waitAck(input int sel, input int budget);
    int            n;
    logic          seen;
    logic [2:0]    vec;
    logic [DW-1:0] d;
    exp_t          e;
    n = 0; seen = 1'b0; vec = 3'b000; d = '0;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (sel == 0) begin
        vec = {scanAck, cpuAck, ldAck};
        d   = scanAck ? scanData : cpuData;
      end else begin
        vec = {bScanAck, bCpuAck, bLdAck};
        d   = bScanAck ? bScanData : bCpuData;
      end
      if (vec != 3'b000) seen = 1'b1;
    end
    e.tag = "sb_empty"; e.ackVec = 3'b000; e.data = '0; e.lat = 0;
    if (sb.size() > 0) e = sb.pop_front();
    checkOutput($sformatf("%s_seen", e.tag), seen, 1);
    checkOutput($sformatf("%s_src", e.tag), vec, e.ackVec);
    checkOutput($sformatf("%s_lat", e.tag), cyc - reqCyc, e.lat);
    if (e.ackVec != 3'b001)
      checkOutput($sformatf("%s_data", e.tag), d, e.data);
  endtask

  initial begin
    rstN = 1'b0; mode = 2'd0;
    ldReq = 0; ldAddr = '0; ldData = '0;
    cpuReq = 0; cpuAddr = '0; scanReq = 0; scanAddr = '0;
    bMode = 2'd2; bLdReq = 0; bLdAddr = '0; bLdData = '0;
    bCpuReq = 0; bCpuAddr = '0; bScanReq = 0; bScanAddr = '0;
    repeat (3) tick();
    rstN = 1'b1;
    tick();

    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rom_en", {romEn, romWe}, 0);
    checkOutput("rst_acks", {scanAck, cpuAck, ldAck}, 0);
    checkOutput("rst_cpu_data", cpuData, 0);
    checkOutput("rst_scan_data", scanData, 0);
    checkOutput("rst_rom_addr", romAddr, 0);
    checkOutput("rst_rom_wdata", romWdata, 0);
    checkOutput("rst_lat3_outs", {bBusy, bRomEn, bRomWe, bRomWdata}, 0);

    // Reset while a write sits in GRANT.
    mode = 2'd0; ldReq = 1; ldAddr = 11'h155; ldData = 16'h1111;
    tick();
    checkOutput("t1_grant_en", romEn, 1);
    rstN = 1'b0; ldReq = 0; ackSeen = 1'b0;
    repeat (2) begin
      tick();
      ackSeen = ackSeen | ldAck | cpuAck | scanAck;
      checkOutput("t1_rst_busy", busy, 0);
    end
    rstN = 1'b1;
    repeat (3) begin
      tick();
      ackSeen = ackSeen | ldAck | cpuAck | scanAck;
    end
    checkOutput("t1_no_ack", ackSeen, 0);
    checkOutput("t1_rom_addr", romAddr, 0);
    checkOutput("t1_rom_en", romEn, 0);

    // Loader write to the top address.
    ldReq = 1; ldAddr = 11'h7FF; ldData = 16'hA5C3;
    reqCyc = cyc; pushExp("t2_ld", 3'b001, '0, 2);
    tick();
    checkOutput("t2_rom_en", romEn, 1);
    checkOutput("t2_rom_we", romWe, 1);
    checkOutput("t2_rom_addr", romAddr, 11'h7FF);
    checkOutput("t2_rom_wdata", romWdata, 16'hA5C3);
    waitAck(0, 8);
    ldReq = 0;
    tick();
    checkOutput("t2_ack_pulse", ldAck, 0);
    checkOutput("t2_idle", busy, 0);

    // CPU reads, including read-back of the loaded word, then a scan read.
    mode = 2'd1; cpuReq = 1; cpuAddr = 11'h020;
    reqCyc = cyc; pushExp("t3_cpu", 3'b010, 16'h1234, 3);
    tick();
    checkOutput("t3_rom_we", romWe, 0);
    checkOutput("t3_rom_addr", romAddr, 11'h020);
    waitAck(0, 8);
    cpuReq = 0;
    tick();
    cpuReq = 1; cpuAddr = 11'h7FF;
    reqCyc = cyc; pushExp("t3_rdback", 3'b010, 16'hA5C3, 3);
    waitAck(0, 8);
    cpuReq = 0;
    repeat (2) tick();
    checkOutput("t3_cpu_hold", cpuData, 16'hA5C3);
    mode = 2'd2; scanReq = 1; scanAddr = 11'h001;
    reqCyc = cyc; pushExp("t3_scan", 3'b100, 16'hBEEF, 3);
    waitAck(0, 8);
    scanReq = 0;
    tick();
    checkOutput("t3_cpu_kept", cpuData, 16'hA5C3);

    // Held cpu and scan requests: scan gets every fifth grant.
    cpuReq = 1; cpuAddr = 11'h030; scanReq = 1; scanAddr = 11'h040;
    reqCyc = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9)
        pushExp($sformatf("t4_g%0d", i), 3'b100, 16'hD040, 3);
      else
        pushExp($sformatf("t4_g%0d", i), 3'b010, 16'hC030, 3);
      waitAck(0, 8);
      reqCyc = cyc + 1;
    end
    cpuReq = 0; scanReq = 0;
    repeat (2) tick();
    checkOutput("t4_idle", busy, 0);

    // Mode 0 blocks the CPU; a mode change mid-write does not disturb the write.
    mode = 2'd0; cpuReq = 1; cpuAddr = 11'h050;
    ackSeen = 1'b0; busySeen = 1'b0;
    repeat (6) begin
      tick();
      ackSeen  = ackSeen | cpuAck;
      busySeen = busySeen | busy;
    end
    checkOutput("t5_cpu_blocked", {busySeen, ackSeen}, 0);
    ldReq = 1; ldAddr = 11'h060; ldData = 16'h0F0F;
    reqCyc = cyc; pushExp("t5_ld", 3'b001, '0, 2);
    tick();
    mode = 2'd1;
    waitAck(0, 8);
    ldReq = 0;
    reqCyc = cyc + 1; pushExp("t5_cpu", 3'b010, 16'h5050, 3);
    waitAck(0, 8);
    cpuReq = 0;
    tick();

    // Mode 3 behaves as debug: loader ignored, scan served.
    mode = 2'd3; ldReq = 1; ldAddr = 11'h100; ldData = 16'hFFFF;
    scanReq = 1; scanAddr = 11'h7FE;
    reqCyc = cyc; pushExp("m3_scan", 3'b100, 16'h7E7E, 3);
    waitAck(0, 8);
    scanReq = 0; ldReq = 0;
    tick();

    // RD_LAT=3 build: longer read latency, scan request dropped during WAIT.
    bCpuReq = 1; bCpuAddr = 11'h020;
    reqCyc = cyc; pushExp("t6_cpu", 3'b010, 16'h1234, 5);
    tick();
    checkOutput("t6_rom_en", {bRomEn, bRomWe}, 2'b10);
    waitAck(1, 12);
    bCpuReq = 0;
    tick();
    bScanReq = 1; bScanAddr = 11'h001;
    reqCyc = cyc; pushExp("t6_scan", 3'b100, 16'hBEEF, 5);
    repeat (2) tick();
    bScanReq = 0;
    waitAck(1, 12);
    ackSeen = 1'b0;
    repeat (8) begin
      tick();
      ackSeen = ackSeen | bScanAck;
    end
    checkOutput("t6_single_ack", ackSeen, 0);
    checkOutput("t6_idle", bBusy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
